// File: rtl/pipe_stall_responder.sv
// pipe_stall_responder: consumer side of the hazard-detection interface.
// Owns the fetch PC, the IF/ID register and the ID/EX bubble request, and
// turns load-use and branch stall requests into bounded PC/IF/ID holds.
// Optional feature macro: STALL_STATS_EN enables the saturating stall
// counters; without it both counter ports are tied to zero.
module pipe_stall_responder #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_load,
  input  logic            branch_dec,
  input  logic            branch_resolve,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic [31:0]     instr_in,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic            id_ex_bubble,
  output logic            misalign,
  output logic [15:0]     load_stall_cnt,
  output logic [15:0]     branch_stall_cnt
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_HOLD = 2'd1,
    BR_WAIT   = 2'd2
  } state_t;

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [31:0]     if_id_instr_reg;
  logic [XLEN-1:0] if_id_pc_reg;
  logic            if_id_valid_reg;
  logic            misalign_reg;
  // Set once a load request has been served and held until the request
  // drops, so a request that stays asserted cannot re-trigger the stall.
  logic            stale_reg;

  logic load_accept;
  logic branch_squash;

  // Request acceptance is decided combinationally so the bubble shows up in
  // the same cycle the load-use hazard is reported.
  assign load_accept   = (state_reg == RUN) && stall_load && !stale_reg;
  assign branch_squash = (state_reg == RUN) && !load_accept && branch_dec && if_id_valid_reg;
  assign id_ex_bubble  = load_accept;

  assign pc_out      = pc_reg;
  assign if_id_instr = if_id_instr_reg;
  assign if_id_pc    = if_id_pc_reg;
  assign if_id_valid = if_id_valid_reg;
  assign misalign    = misalign_reg;

  // Stall FSM: sequences PC and IF/ID updates for RUN, LOAD_HOLD and BR_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      if_id_instr_reg <= NOP_INSTR;
      if_id_pc_reg    <= '0;
      if_id_valid_reg <= 1'b0;
      misalign_reg    <= 1'b0;
      stale_reg       <= 1'b0;
    end else begin
      misalign_reg <= 1'b0;
      stale_reg    <= stall_load && (stale_reg || load_accept);
      case (state_reg)
        RUN: begin
          if (load_accept) begin
            // PC and IF/ID hold while the bubble goes down the pipe.
            state_reg <= LOAD_HOLD;
          end else if (branch_squash) begin
            // pc_reg already points at the fall-through; drop the shadow fetch.
            if_id_valid_reg <= 1'b0;
            state_reg       <= BR_WAIT;
          end else begin
            pc_reg          <= pc_reg + XLEN'(4);
            if_id_instr_reg <= instr_in;
            if_id_pc_reg    <= pc_reg;
            if_id_valid_reg <= 1'b1;
          end
        end
        LOAD_HOLD: begin
          pc_reg          <= pc_reg + XLEN'(4);
          if_id_instr_reg <= instr_in;
          if_id_pc_reg    <= pc_reg;
          if_id_valid_reg <= 1'b1;
          state_reg       <= RUN;
        end
        BR_WAIT: begin
          if_id_valid_reg <= 1'b0;
          if (branch_resolve) begin
            if (branch_taken) begin
              pc_reg       <= {branch_target[XLEN-1:2], 2'b00};
              misalign_reg <= |branch_target[1:0];
            end
            state_reg <= RUN;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

`ifdef STALL_STATS_EN
  logic [15:0] load_cnt_reg;
  logic [15:0] branch_cnt_reg;

  // Saturating stall statistics; the branch count includes the squash cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_reg   <= '0;
      branch_cnt_reg <= '0;
    end else begin
      if (load_accept && (load_cnt_reg != 16'hFFFF))
        load_cnt_reg <= load_cnt_reg + 16'd1;
      if ((branch_squash || (state_reg == BR_WAIT)) && (branch_cnt_reg != 16'hFFFF))
        branch_cnt_reg <= branch_cnt_reg + 16'd1;
    end
  end

  assign load_stall_cnt   = load_cnt_reg;
  assign branch_stall_cnt = branch_cnt_reg;
`else
  assign load_stall_cnt   = 16'd0;
  assign branch_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_responder.sv
// Self-checking bench for pipe_stall_responder: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_pipe_stall_responder;

`ifdef STALL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_load = 1'b0;
  logic        branch_dec = 1'b0;
  logic        branch_resolve = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        id_ex_bubble;
  logic        misalign;
  logic [15:0] load_stall_cnt;
  logic [15:0] branch_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign instr_in = imem(pc_out);

  pipe_stall_responder #(.XLEN(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .stall_load(stall_load), .branch_dec(branch_dec),
    .branch_resolve(branch_resolve), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_in(instr_in), .pc_out(pc_out),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .id_ex_bubble(id_ex_bubble), .misalign(misalign),
    .load_stall_cnt(load_stall_cnt), .branch_stall_cnt(branch_stall_cnt)
  );

  // Behavioural model: what the pipeline front end should look like after each edge.
  logic [31:0] m_pc, m_instr, m_ifpc;
  bit          m_valid, m_mis;
  int          m_lcnt, m_bcnt;
  bit          m_in_penalty;  // serving the single load-use penalty cycle
  bit          m_awaiting;    // branch squashed, outcome pending
  bit          m_stale;       // asserted load request already served
  bit          exp_bubble, obs_bubble;

  task automatic model_step();
    bit take_load, take_branch, advance;
    take_load   = !m_in_penalty && !m_awaiting && stall_load && !m_stale;
    exp_bubble  = take_load;
    if (reset) begin
      m_pc = 32'h100; m_instr = 32'h13; m_ifpc = 0; m_valid = 0; m_mis = 0;
      m_lcnt = 0; m_bcnt = 0; m_in_penalty = 0; m_awaiting = 0; m_stale = 0;
      return;
    end
    take_branch = !m_in_penalty && !m_awaiting && !take_load && branch_dec && m_valid;
    advance     = m_in_penalty || (!m_awaiting && !take_load && !take_branch);
    m_mis   = 0;
    m_stale = stall_load && (m_stale || take_load);
    if (advance) begin
      m_instr = imem(m_pc); m_ifpc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
    end
    if (take_branch || m_awaiting) begin
      m_valid = 0;
      if (STATS && m_bcnt < 65535) m_bcnt++;
    end
    if (take_load && STATS && m_lcnt < 65535) m_lcnt++;
    if (m_awaiting && branch_resolve && branch_taken) begin
      m_pc  = {branch_target[31:2], 2'b00};
      m_mis = (branch_target[1:0] != 2'b00);
    end
    m_awaiting   = take_branch || (m_awaiting && !branch_resolve);
    m_in_penalty = take_load;
  endtask

  // One clock: sample the combinational bubble mid-cycle, then step past the edge.
  task automatic tick();
    @(negedge clk);
    obs_bubble = id_ex_bubble;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall_load = 0; branch_dec = 0; branch_resolve = 0; branch_taken = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h100); end
    n_checks++; if (if_id_instr !== 32'h13) begin n_fail++; $display("FAIL reset_instr: got %h want %h", if_id_instr, 32'h13); end
    n_checks++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ifpc: got %h want 0", if_id_pc); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    n_checks++; if (load_stall_cnt !== 16'd0 || branch_stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", load_stall_cnt, branch_stall_cnt); end
    $display("reset: pc=%h valid=%b", pc_out, if_id_valid);
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 32'h100 + 32'(4 * i);
      n_checks++; if (pc_out !== exp_pc) begin n_fail++; $display("FAIL free_pc: got %h want %h", pc_out, exp_pc); end
      n_checks++; if (if_id_valid !== 1'b1 || if_id_pc !== exp_pc - 32'd4 || if_id_instr !== imem(exp_pc - 32'd4)) begin
        n_fail++; $display("FAIL free_ifid: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                           if_id_valid, if_id_pc, if_id_instr, exp_pc - 32'd4, imem(exp_pc - 32'd4)); end
      $display("free_run: pc=%h if_id_pc=%h", pc_out, if_id_pc);
    end
  endtask

  task automatic test_load_stall();
    logic [31:0] exp_pcs [3];
    exp_pcs[0] = 32'h108; exp_pcs[1] = 32'h10C; exp_pcs[2] = 32'h110;
    do_reset(); tick(); tick();
    stall_load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (obs_bubble !== (i == 0)) begin n_fail++; $display("FAIL load_bubble[%0d]: got %b want %b", i, obs_bubble, i == 0); end
      n_checks++; if (pc_out !== exp_pcs[i]) begin n_fail++; $display("FAIL load_pc[%0d]: got %h want %h", i, pc_out, exp_pcs[i]); end
      $display("load_stall: bubble=%b pc=%h", obs_bubble, pc_out);
    end
    stall_load = 1'b0;
    n_checks++; if (load_stall_cnt !== (STATS ? 16'd1 : 16'd0)) begin
      n_fail++; $display("FAIL load_cnt: got %0d want %0d", load_stall_cnt, STATS ? 1 : 0); end
  endtask

  task automatic test_branch_taken();
    do_reset(); for (int i = 0; i < 4; i++) tick();
    branch_dec = 1'b1; tick(); branch_dec = 1'b0;
    n_checks++; if (if_id_valid !== 1'b0 || pc_out !== 32'h110) begin n_fail++; $display("FAIL br_squash: got v=%b pc=%h want v=0 pc=110", if_id_valid, pc_out); end
    tick();
    n_checks++; if (if_id_valid !== 1'b0 || pc_out !== 32'h110) begin n_fail++; $display("FAIL br_wait: got v=%b pc=%h want v=0 pc=110", if_id_valid, pc_out); end
    branch_resolve = 1'b1; branch_taken = 1'b1; branch_target = 32'h200; tick();
    branch_resolve = 1'b0; branch_taken = 1'b0;
    n_checks++; if (if_id_valid !== 1'b0 || pc_out !== 32'h200 || misalign !== 1'b0) begin
      n_fail++; $display("FAIL br_redirect: got v=%b pc=%h mis=%b want v=0 pc=200 mis=0", if_id_valid, pc_out, misalign); end
    n_checks++; if (branch_stall_cnt !== (STATS ? 16'd3 : 16'd0)) begin
      n_fail++; $display("FAIL br_cnt: got %0d want %0d", branch_stall_cnt, STATS ? 3 : 0); end
    tick();
    n_checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || pc_out !== 32'h204) begin
      n_fail++; $display("FAIL br_resume: got v=%b ifpc=%h pc=%h want v=1 ifpc=200 pc=204", if_id_valid, if_id_pc, pc_out); end
    $display("branch_taken: pc=%h cnt=%0d", pc_out, branch_stall_cnt);
  endtask

  task automatic test_branch_not_taken();
    do_reset(); for (int i = 0; i < 4; i++) tick();
    branch_dec = 1'b1; tick(); branch_dec = 1'b0;
    branch_resolve = 1'b1; branch_taken = 1'b0; branch_target = 32'h3; tick();
    branch_resolve = 1'b0;
    n_checks++; if (pc_out !== 32'h110 || misalign !== 1'b0) begin n_fail++; $display("FAIL nt_pc: got pc=%h mis=%b want pc=110 mis=0", pc_out, misalign); end
    tick();
    n_checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h110 || pc_out !== 32'h114 || misalign !== 1'b0) begin
      n_fail++; $display("FAIL nt_resume: got v=%b ifpc=%h pc=%h mis=%b want v=1 ifpc=110 pc=114 mis=0", if_id_valid, if_id_pc, pc_out, misalign); end
    $display("branch_not_taken: pc=%h", pc_out);
  endtask

  task automatic test_stall_and_branch();
    do_reset(); for (int i = 0; i < 4; i++) tick();
    stall_load = 1'b1; branch_dec = 1'b1; tick(); stall_load = 1'b0;
    n_checks++; if (obs_bubble !== 1'b1 || pc_out !== 32'h110) begin n_fail++; $display("FAIL sb_bubble: got b=%b pc=%h want b=1 pc=110", obs_bubble, pc_out); end
    tick();
    n_checks++; if (obs_bubble !== 1'b0 || pc_out !== 32'h114 || if_id_valid !== 1'b1) begin
      n_fail++; $display("FAIL sb_hold: got b=%b pc=%h v=%b want b=0 pc=114 v=1", obs_bubble, pc_out, if_id_valid); end
    tick(); branch_dec = 1'b0;
    n_checks++; if (pc_out !== 32'h114 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL sb_squash: got pc=%h v=%b want pc=114 v=0", pc_out, if_id_valid); end
    stall_load = 1'b1; branch_resolve = 1'b1; branch_taken = 1'b1; branch_target = 32'h202; tick();
    stall_load = 1'b0; branch_resolve = 1'b0; branch_taken = 1'b0;
    n_checks++; if (obs_bubble !== 1'b0) begin n_fail++; $display("FAIL sb_brwait_bubble: got %b want 0", obs_bubble); end
    n_checks++; if (pc_out !== 32'h200 || misalign !== 1'b1) begin n_fail++; $display("FAIL sb_misalign: got pc=%h mis=%b want pc=200 mis=1", pc_out, misalign); end
    tick();
    n_checks++; if (misalign !== 1'b0 || pc_out !== 32'h204) begin n_fail++; $display("FAIL sb_pulse: got mis=%b pc=%h want mis=0 pc=204", misalign, pc_out); end
    $display("stall_and_branch: pc=%h", pc_out);
  endtask

  task automatic test_reset_in_br_wait();
    do_reset(); for (int i = 0; i < 4; i++) tick();
    branch_dec = 1'b1; tick(); branch_dec = 1'b0; tick();
    do_reset();
    n_checks++; if (pc_out !== 32'h100 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rbw_reset: got pc=%h v=%b want pc=100 v=0", pc_out, if_id_valid); end
    branch_resolve = 1'b1; branch_taken = 1'b1; branch_target = 32'h301; tick();
    branch_resolve = 1'b0; branch_taken = 1'b0;
    n_checks++; if (pc_out !== 32'h104 || if_id_valid !== 1'b1 || misalign !== 1'b0) begin
      n_fail++; $display("FAIL rbw_ignore: got pc=%h v=%b mis=%b want pc=104 v=1 mis=0", pc_out, if_id_valid, misalign); end
    $display("reset_in_br_wait: pc=%h", pc_out);
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(63) == 0);
      stall_load     = ($urandom_range(3) == 0);
      branch_dec     = ($urandom_range(2) == 0);
      branch_resolve = ($urandom_range(2) == 0);
      branch_taken   = $urandom_range(1) == 1;
      branch_target  = $urandom;
      tick();
      if (!reset) begin
        n_checks++; if (obs_bubble !== exp_bubble) begin n_fail++; errs++; $display("FAIL rnd_bubble[%0d]: got %b want %b", i, obs_bubble, exp_bubble); end
      end
      n_checks++; if (pc_out !== m_pc) begin n_fail++; errs++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc_out, m_pc); end
      n_checks++; if (if_id_valid !== m_valid || (m_valid && (if_id_pc !== m_ifpc || if_id_instr !== m_instr))) begin
        n_fail++; errs++; $display("FAIL rnd_ifid[%0d]: got v=%b pc=%h ins=%h want v=%b pc=%h ins=%h",
                                   i, if_id_valid, if_id_pc, if_id_instr, m_valid, m_ifpc, m_instr); end
      n_checks++; if (misalign !== m_mis) begin n_fail++; errs++; $display("FAIL rnd_mis[%0d]: got %b want %b", i, misalign, m_mis); end
      n_checks++; if (load_stall_cnt !== 16'(m_lcnt) || branch_stall_cnt !== 16'(m_bcnt)) begin
        n_fail++; errs++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, load_stall_cnt, branch_stall_cnt, m_lcnt, m_bcnt); end
    end
    reset = 1'b0; stall_load = 0; branch_dec = 0; branch_resolve = 0; branch_taken = 0;
    $display("random: 400 cycles, %0d mismatching cycles", errs);
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_load_stall();
    test_branch_taken();
    test_branch_not_taken();
    test_stall_and_branch();
    test_reset_in_br_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
